// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared types and helpers for the PWM capture block and its input stage.
//   pwm_state_e : capture FSM state (SEEK waits for a rising edge,
//                 MEASURE times frames between rising edges)
//   frame_len() : nominal frame length, 2^width cycles
//   cnt_width() : frame counter width, one bit wider than the level so the
//                 full frame length 2^width is representable
// ---------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } pwm_state_e;

    // Extra counter bits beyond the level width.
    localparam int CNT_EXTRA_BITS = 1;

    function automatic int frame_len(input int width);
        return 1 << width;
    endfunction

    function automatic int cnt_width(input int width);
        return width + CNT_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
// Bundles the PWM pin and the decoded result of pwm_capture.
//   pwm_in     : asynchronous PWM waveform into the capture block
//   level      : last recovered duty level (high cycles per frame)
//   valid      : one-cycle strobe, level has just been updated
//   period_err : one-cycle strobe, frame length was wrong, level unchanged
//   locked     : set after a good frame, cleared by error / stuck / reset
//   state      : capture FSM state, exported for debug and checkers
//
// Handshake: valid and period_err are pure strobes with no ready/back-
// pressure. Each lasts exactly one clk cycle, the two are never high in the
// same cycle, and the consumer must take level on the valid cycle.
//
// Modports: master = capture block side, slave = consumer / pin driver side.
// ---------------------------------------------------------------------------
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             pwm_in;
    logic [WIDTH-1:0] level;
    logic             valid;
    logic             period_err;
    logic             locked;
    pwm_state_e       state;

    modport master (
        input  pwm_in,
        output level,
        output valid,
        output period_err,
        output locked,
        output state
    );

    modport slave (
        output pwm_in,
        input  level,
        input  valid,
        input  period_err,
        input  locked,
        input  state
    );

endinterface

// File: rtl/pwm_in_sync.sv
// ---------------------------------------------------------------------------
// pwm_in_sync
// Brings an asynchronous PWM pin into the clk domain and flags rising edges.
//   clk, reset_n : clock and synchronous active-low reset
//   pwm_in       : asynchronous pin
//   pwm_s        : synchronised (optionally inverted / filtered) level
//   rise         : pwm_s is 1 this cycle and was 0 the previous cycle
//
// Parameter INVERT = 1 treats the pin as active-low; the inversion is applied
// after the two synchroniser flops.
//
// Build option PWM_CAPTURE_FILTER_EN: when defined, pwm_s is the majority of
// the last three synchronised samples, which rejects single-cycle glitches
// and adds one cycle of latency. When undefined, pwm_s is the synchroniser
// output directly.
// ---------------------------------------------------------------------------
module pwm_in_sync #(
    parameter bit INVERT = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic pwm_dly_q, pwm_dly_d;
    logic sync_s;

    always_comb begin
        sync1_d   = pwm_in;
        sync2_d   = sync1_q;
        sync_s    = sync2_q ^ INVERT;
        pwm_dly_d = pwm_s;
        rise      = pwm_s & ~pwm_dly_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pwm_dly_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pwm_dly_q <= pwm_dly_d;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;

    // Two of the last three samples must agree, so an isolated one-cycle
    // pulse never reaches pwm_s while both edges of a real pulse are delayed
    // by the same single cycle, preserving the high-cycle count.
    always_comb begin
        hist1_d = sync_s;
        hist2_d = hist1_q;
        pwm_s   = (sync_s & hist1_q) | (sync_s & hist2_q) | (hist1_q & hist2_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
        end
    end
`else
    always_comb begin
        pwm_s = sync_s;
    end
`endif

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Recovers the duty level of a PWM waveform whose frame is 2^WIDTH clk
// cycles long (counterpart of the team PWM generator).
//   clk, reset_n : clock and synchronous active-low reset
//   bus (master) : pwm_in in; level, valid, period_err, locked, state out
//
// Frames are measured rising edge to rising edge. A frame of exactly
// 2^WIDTH cycles publishes its high-cycle count on level with a valid strobe
// and sets locked. Any other length pulses period_err and drops locked. If
// 2^WIDTH cycles pass with no rising edge the input is stuck: level reports
// all-ones or zero from the current pin value with a valid strobe, locked
// drops and the FSM returns to SEEK. This repeats while the input is static.
//
// Parameters: WIDTH (level width), INVERT (active-low input).
// Build option PWM_CAPTURE_FILTER_EN enables the glitch filter inside
// pwm_in_sync; counting is unchanged.
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit INVERT = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    pwm_capture_if.master bus
);

    localparam int              CW    = cnt_width(WIDTH);
    localparam logic [CW-1:0]   FRAME = CW'(frame_len(WIDTH));

    logic pwm_s;
    logic rise;

    pwm_in_sync #(
        .INVERT (INVERT)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pwm_in  (bus.pwm_in),
        .pwm_s   (pwm_s),
        .rise    (rise)
    );

    pwm_state_e       state_q, state_d;
    logic [CW-1:0]    period_cnt_q, period_cnt_d;
    logic [CW-1:0]    high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic             period_err_q, period_err_d;
    logic             locked_q, locked_d;
    logic             timeout;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        level_d      = level_q;
        valid_d      = 1'b0;
        period_err_d = 1'b0;
        locked_d     = locked_q;

        // A full frame elapsed without an edge; applies in both states, and
        // a rise in the same cycle takes precedence as a normal frame end.
        timeout = (period_cnt_q == FRAME) && !rise;

        if (timeout) begin
            level_d      = {WIDTH{pwm_s}};
            valid_d      = 1'b1;
            locked_d     = 1'b0;
            period_cnt_d = CW'(1);
            high_cnt_d   = CW'(pwm_s);
            state_d      = SEEK;
        end else if (rise) begin
            // The rise cycle itself is high, so both counters restart at 1.
            period_cnt_d = CW'(1);
            high_cnt_d   = CW'(1);
            state_d      = MEASURE;
            if (state_q == MEASURE) begin
                if (period_cnt_q == FRAME) begin
                    level_d  = high_cnt_q[WIDTH-1:0];
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end else begin
                    period_err_d = 1'b1;
                    locked_d     = 1'b0;
                end
            end
        end else begin
            period_cnt_d = period_cnt_q + CW'(1);
            high_cnt_d   = high_cnt_q + CW'(pwm_s);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= SEEK;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            level_q      <= '0;
            valid_q      <= 1'b0;
            period_err_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            level_q      <= level_d;
            valid_q      <= valid_d;
            period_err_q <= period_err_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.level      = level_q;
    assign bus.valid      = valid_q;
    assign bus.period_err = period_err_q;
    assign bus.locked     = locked_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
// Drives PWM frames into pwm_capture and checks every valid / period_err
// strobe against a frame-level reference model. The model keeps a log of
// the synchronised waveform, finds rising edges, and derives the frame
// length and high count by subtraction and summation over that log.
// ---------------------------------------------------------------------------
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int WIDTH   = 8;
    localparam int FRAME   = 1 << WIDTH;
    localparam int EW      = 32 + 2 + WIDTH;   // {due cycle, is_err, locked, level}
    localparam int MAX_CYC = 60000;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.WIDTH(WIDTH)) bus ();

    pwm_capture #(
        .WIDTH  (WIDTH),
        .INVERT (1'b0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    bit               pin_pipe [4];   // sync1, sync2, older sample, oldest sample
    bit               s_prev;
    bit               m_seek;
    int               anchor;         // cycle whose sample opens the current frame
    logic [WIDTH-1:0] m_level;
    bit               s_log [MAX_CYC];

    function automatic bit model_s();
`ifdef PWM_CAPTURE_FILTER_EN
        int votes;
        votes = int'(pin_pipe[1]) + int'(pin_pipe[2]) + int'(pin_pipe[3]);
        return votes >= 2;
`else
        return pin_pipe[1];
`endif
    endfunction

    function automatic int ones(input int from, input int to_excl);
        int n;
        n = 0;
        for (int i = from; i < to_excl; i++) n += int'(s_log[i]);
        return n;
    endfunction

    function automatic void push_exp(input bit is_err, input bit lk, input logic [WIDTH-1:0] lv);
        exp_q.push_back({32'(cyc), is_err, lk, lv});
    endfunction

    always @(posedge clk) begin
        bit s_cur;
        bit rise;
        int len;
        cyc = cyc + 1;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) pin_pipe[i] = 1'b0;
            s_prev  = 1'b0;
            m_seek  = 1'b1;
            anchor  = cyc + 1;
            m_level = '0;
        end else begin
            s_cur = model_s();
            rise  = s_cur && !s_prev;
            len   = cyc - anchor;
            if (!rise && len == FRAME) begin
                m_level = s_cur ? '1 : '0;
                push_exp(1'b0, 1'b0, m_level);
                m_seek = 1'b1;
                anchor = cyc;
            end else if (rise) begin
                if (!m_seek) begin
                    if (len == FRAME) begin
                        m_level = WIDTH'(ones(anchor, cyc));
                        push_exp(1'b0, 1'b1, m_level);
                    end else begin
                        push_exp(1'b1, 1'b0, m_level);
                    end
                end
                m_seek = 1'b0;
                anchor = cyc;
            end
            s_log[cyc]  = s_cur;
            s_prev      = s_cur;
            pin_pipe[3] = pin_pipe[2];
            pin_pipe[2] = pin_pipe[1];
            pin_pipe[1] = pin_pipe[0];
            pin_pipe[0] = bus.pwm_in;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int due;
        if (bus.valid === 1'b1 && bus.period_err === 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL both_strobes: valid and period_err high together at cyc %0d", cyc);
        end
        if (bus.valid === 1'b1 || bus.period_err === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: got err=%0b level=%0d at cyc %0d, expected no strobe",
                         bus.period_err, bus.level, cyc);
            end else begin
                e   = exp_q.pop_front();
                due = int'(e[EW-1 -: 32]);
                if (due != cyc || bus.period_err !== e[WIDTH+1] ||
                    bus.locked !== e[WIDTH] || bus.level !== e[WIDTH-1:0]) begin
                    n_err++;
                    $display("FAIL strobe: got cyc=%0d err=%0b locked=%0b level=%0d, expected cyc=%0d err=%0b locked=%0b level=%0d",
                             cyc, bus.period_err, bus.locked, bus.level,
                             due, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
                end
            end
        end else if (exp_q.size() > 0) begin
            e   = exp_q[0];
            due = int'(e[EW-1 -: 32]);
            if (due <= cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_strobe: got none at cyc %0d, expected err=%0b level=%0d due cyc %0d",
                         cyc, e[WIDTH+1], e[WIDTH-1:0], due);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v);
        bus.pwm_in = v;
        @(negedge clk);
    endtask

    task automatic gen(input int lvl, input int nframes);
        for (int f = 0; f < nframes; f++)
            for (int i = 0; i < FRAME; i++) drive(i < lvl);
    endtask

    task automatic frame_custom(input int len, input int high);
        for (int i = 0; i < len; i++) drive(i < high);
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (bus.level !== '0 || bus.valid !== 1'b0 || bus.period_err !== 1'b0 ||
            bus.locked !== 1'b0 || bus.state !== SEEK) begin
            n_err++;
            $display("FAIL %s: got level=%0d valid=%0b err=%0b locked=%0b state=%0d, expected all zero / SEEK",
                     name, bus.level, bus.valid, bus.period_err, bus.locked, bus.state);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.pwm_in = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;

        // Steady level 64, then several random levels.
        gen(64, 5);
        repeat (4) gen(int'($urandom_range(1, FRAME - 2)), 3);

        // Level 0: constant low, stuck timeouts report 0.
        gen(0, 3);

        // Level 255, then pin held high.
        gen(FRAME - 1, 3);
        repeat (600) drive(1'b1);

        // Short 200-cycle frame between good frames.
        gen(64, 2);
        frame_custom(200, 50);
        gen(64, 3);

        // Level change 64 -> 192 mid-frame.
        frame_custom(100, 64);
        gen(192, 4);

        // One-cycle reset mid-frame.
        frame_custom(120, 64);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle("reset_mid");
        reset_n = 1'b1;
        gen(64, 4);

        // Single-cycle glitch in the low part of a level-64 frame.
        gen(64, 2);
        for (int i = 0; i < FRAME; i++) drive(i < 64 || i == 150);
        gen(64, 3);

        repeat (10) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected strobes, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
